// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, prescale width and rx FSM states.
package uart_pkg;

  // Clocks per bit are prescale * OVERSAMPLE.
  localparam int OVERSAMPLE     = 8;
  localparam int PRESCALE_WIDTH = 16;
  // Wide enough for prescale * OVERSAMPLE - 1 with a full 16-bit prescale.
  localparam int COUNT_WIDTH    = 19;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // A prescale of zero would stall the bit timer, so it runs as one.
  function automatic logic [PRESCALE_WIDTH-1:0] eff_prescale(input logic [PRESCALE_WIDTH-1:0] p);
    return (p == '0) ? PRESCALE_WIDTH'(1) : p;
  endfunction

  // Reload value for a full bit period.
  function automatic logic [COUNT_WIDTH-1:0] bit_period(input logic [PRESCALE_WIDTH-1:0] p);
    return COUNT_WIDTH'(p) * COUNT_WIDTH'(OVERSAMPLE) - COUNT_WIDTH'(1);
  endfunction

  // Reload value for half a bit period (start bit to mid-bit alignment).
  function automatic logic [COUNT_WIDTH-1:0] half_period(input logic [PRESCALE_WIDTH-1:0] p);
    return COUNT_WIDTH'(p) * COUNT_WIDTH'(OVERSAMPLE / 2) - COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs with a configurable reset value.
module uart_sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two back-to-back flops to resolve metastability on the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VALUE;
      sync_reg <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1-style receiver with oversampled mid-bit sampling and an AXI4-Stream output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [DATA_WIDTH-1:0]     output_axis_tdata,
  output logic                      output_axis_tvalid,
  input  logic                      output_axis_tready,
  input  logic                      rxd,
  output logic                      busy,
  output logic                      overrun_error,
  output logic                      frame_error,
  input  logic [PRESCALE_WIDTH-1:0] prescale
);

  logic                      rxd_s;
  rx_state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0]    count_reg, count_next;
  logic [3:0]                bit_cnt_reg, bit_cnt_next;
  logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
  logic [DATA_WIDTH-1:0]     shift_reg, shift_next;
  logic                      busy_reg, busy_next;
  logic                      frame_done;
  logic                      frame_bad;
  logic [DATA_WIDTH-1:0]     tdata_reg;
  logic                      tvalid_reg;
  logic                      overrun_reg;
  logic                      frame_error_reg;

  uart_sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_rxd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // Frame state and timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      bit_cnt_reg  <= '0;
      prescale_reg <= '0;
      shift_reg    <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      bit_cnt_reg  <= bit_cnt_next;
      prescale_reg <= prescale_next;
      shift_reg    <= shift_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state logic: half-bit alignment on the start bit, then one sample per bit period.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    bit_cnt_next  = bit_cnt_reg;
    prescale_next = prescale_reg;
    shift_next    = shift_reg;
    busy_next     = busy_reg;
    frame_done    = 1'b0;
    frame_bad     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rxd_s) begin
          prescale_next = eff_prescale(prescale);
          count_next    = half_period(eff_prescale(prescale));
          busy_next     = 1'b1;
          state_next    = START;
        end
      end
      START: begin
        if (count_reg == '0) begin
          if (rxd_s) begin
            // Line went back high before mid-bit: treat as a glitch.
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            count_next   = bit_period(prescale_reg);
            bit_cnt_next = 4'(DATA_WIDTH);
            state_next   = DATA;
          end
        end else begin
          count_next = count_reg - COUNT_WIDTH'(1);
        end
      end
      DATA: begin
        if (count_reg == '0) begin
          shift_next   = {rxd_s, shift_reg[DATA_WIDTH-1:1]};
          bit_cnt_next = bit_cnt_reg - 4'd1;
          count_next   = bit_period(prescale_reg);
          if (bit_cnt_reg == 4'd1) begin
            state_next = STOP;
          end
        end else begin
          count_next = count_reg - COUNT_WIDTH'(1);
        end
      end
      STOP: begin
        if (count_reg == '0) begin
          if (rxd_s) begin
            frame_done = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          count_next = count_reg - COUNT_WIDTH'(1);
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line idles so a break cannot look like a start bit.
        if (rxd_s) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Stream output register and single-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_reg       <= '0;
      tvalid_reg      <= 1'b0;
      overrun_reg     <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      overrun_reg     <= 1'b0;
      frame_error_reg <= frame_bad;
      if (frame_done) begin
        // A simultaneous handshake frees the slot, so only an unconsumed word is an overrun.
        tdata_reg   <= shift_reg;
        tvalid_reg  <= 1'b1;
        overrun_reg <= tvalid_reg && !output_axis_tready;
      end else if (tvalid_reg && output_axis_tready) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

  assign output_axis_tdata  = tdata_reg;
  assign output_axis_tvalid = tvalid_reg;
  assign busy               = busy_reg;
  assign overrun_error      = overrun_reg;
  assign frame_error        = frame_error_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a word queue.
module tb_uart_rx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          rxd = 1'b1;
  logic          busy;
  logic          ovr;
  logic          ferr;
  logic [15:0]   prescale = 16'd1;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .output_axis_tdata  (tdata),
    .output_axis_tvalid (tvalid),
    .output_axis_tready (tready),
    .rxd                (rxd),
    .busy               (busy),
    .overrun_error      (ovr),
    .frame_error        (ferr),
    .prescale           (prescale)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] exp_q[$];
  int tvalid_cnt = 0;
  int busy_cnt   = 0;
  int ovr_cnt    = 0;
  int ferr_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Observe outputs mid-cycle; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (tvalid) tvalid_cnt++;
    if (busy) busy_cnt++;
    if (ovr) ovr_cnt++;
    if (ferr) ferr_cnt++;
    if (tvalid && tready) begin
      rx_q.push_back(tdata);
      $display("rx word 0x%02h at %0t", tdata, $time);
    end
  end

  task automatic clear_stats();
    rx_q.delete();
    tvalid_cnt = 0;
    busy_cnt   = 0;
    ovr_cnt    = 0;
    ferr_cnt   = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_t(input logic [15:0] p);
    return ((p == 16'd0) ? 1 : int'(p)) * 8;
  endfunction

  // Busy lasts from the cycle after start detection up to the stop-bit sample.
  function automatic int busy_len(input int t);
    return t / 2 + (DW + 1) * t;
  endfunction

  task automatic send_frame(input logic [DW-1:0] data, input logic stop, input int t);
    rxd = 1'b0;
    wait_cycles(t);
    for (int k = 0; k < DW; k++) begin
      rxd = data[k];
      wait_cycles(t);
    end
    rxd = stop;
    wait_cycles(t);
  endtask

  logic [DW-1:0] rnd;
  logic [15:0]   rp;

  initial begin
    // Reset state
    wait_cycles(3);
    check_eq("rst_tvalid", tvalid, 0);
    check_eq("rst_tdata", tdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovr", ovr, 0);
    check_eq("rst_ferr", ferr, 0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Single 0x55 frame at T=8
    clear_stats();
    prescale = 16'd1;
    send_frame(8'h55, 1'b1, 8);
    wait_cycles(20);
    check_eq("t1_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("t1_data", rx_q[0], 8'h55);
    check_eq("t1_tvalid_len", tvalid_cnt, 1);
    check_eq("t1_busy_len", busy_cnt, busy_len(8));
    check_eq("t1_ovr", ovr_cnt, 0);
    check_eq("t1_ferr", ferr_cnt, 0);

    // Back-to-back frames with no consumer: overrun on the second
    clear_stats();
    tready = 1'b0;
    send_frame(8'hA3, 1'b1, 8);
    send_frame(8'h3C, 1'b1, 8);
    wait_cycles(20);
    check_eq("t2_ovr", ovr_cnt, 1);
    check_eq("t2_tdata", tdata, 8'h3C);
    check_eq("t2_tvalid", tvalid, 1);
    tready = 1'b1;
    wait_cycles(3);
    check_eq("t2_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("t2_data", rx_q[0], 8'h3C);
    check_eq("t2_tvalid_drop", tvalid, 0);

    // Stop bit low followed by a held break
    clear_stats();
    send_frame(8'h00, 1'b0, 8);
    wait_cycles(20);
    check_eq("t3_ferr", ferr_cnt, 1);
    check_eq("t3_count", rx_q.size(), 0);
    check_eq("t3_busy_hold", busy, 1);
    rxd = 1'b1;
    wait_cycles(8);
    check_eq("t3_busy_rel", busy, 0);
    clear_stats();
    send_frame(8'hFF, 1'b1, 8);
    wait_cycles(20);
    check_eq("t3_ff_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("t3_ff_data", rx_q[0], 8'hFF);
    check_eq("t3_ff_ferr", ferr_cnt, 0);

    // Short glitch at T=32
    clear_stats();
    prescale = 16'd4;
    rxd = 1'b0;
    wait_cycles(3);
    rxd = 1'b1;
    wait_cycles(60);
    check_eq("t4_busy_len", busy_cnt, bit_t(16'd4) / 2);
    check_eq("t4_count", rx_q.size(), 0);
    check_eq("t4_ferr", ferr_cnt, 0);
    check_eq("t4_ovr", ovr_cnt, 0);

    // Reset asserted mid-frame
    prescale = 16'd1;
    clear_stats();
    fork
      send_frame(8'h81, 1'b1, 8);
      begin
        wait_cycles(40);
        check_eq("t5_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_tvalid", tvalid, 0);
        check_eq("t5_tdata", tdata, 0);
        check_eq("t5_ferr", ferr, 0);
      end
    join
    wait_cycles(10);
    check_eq("t5_abort_count", rx_q.size(), 0);
    check_eq("t5_abort_ferr", ferr_cnt, 0);
    rst_n = 1'b1;
    wait_cycles(5);
    clear_stats();
    send_frame(8'h81, 1'b1, 8);
    wait_cycles(20);
    check_eq("t5_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("t5_data", rx_q[0], 8'h81);

    // Prescale zero behaves as one
    clear_stats();
    prescale = 16'd0;
    send_frame(8'h5A, 1'b1, bit_t(16'd0));
    wait_cycles(20);
    check_eq("t6_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("t6_data", rx_q[0], 8'h5A);
    check_eq("t6_busy_len", busy_cnt, busy_len(8));

    // Randomized frames, bit rates and inter-frame gaps
    clear_stats();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      rp       = 16'($urandom_range(0, 3));
      rnd      = DW'($urandom);
      prescale = rp;
      exp_q.push_back(rnd);
      send_frame(rnd, 1'b1, bit_t(rp));
      wait_cycles($urandom_range(0, 4));
    end
    wait_cycles(40);
    check_eq("rnd_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check_eq($sformatf("rnd_data%0d", i), rx_q[i], exp_q[i]);
    end
    check_eq("rnd_ferr", ferr_cnt, 0);
    check_eq("rnd_ovr", ovr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the AXI4-Stream UART transmitter. It oversamples the serial rxd line, frames 8N1 characters and presents each received word on an AXI4-Stream master output. It sits between the board pin and the core's stream fabric, and uses the same 16-bit prescale configuration word as the transmitter. Bit period T = prescale*8 clk cycles.

Parameters:
DATA_WIDTH, 8, number of data bits per character (LSB first); legal range 5..9.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous reset, active-low; clears all state immediately.
output_axis_tdata  output  DATA_WIDTH  received character.
output_axis_tvalid  output  1  tdata holds an unconsumed character.
output_axis_tready  input  1  downstream accepts the character.
rxd  input  1  asynchronous serial input; idle high.
busy  output  1  high from start-bit detection until the frame completes or is aborted.
overrun_error  output  1  one-cycle pulse: a new character overwrote an unconsumed one.
frame_error  output  1  one-cycle pulse: stop bit sampled low.
prescale  input  16  bit-rate divider; T = prescale*8 clocks.

Behaviour:
- Reset values: tdata 0, tvalid 0, busy 0, overrun_error 0, frame_error 0. Both synchronizer flops reset to 1. State is IDLE and counters are 0.
- rxd passes through a 2-flop synchronizer (rxd_s). All references below use rxd_s, so there are 2 cycles of input latency.
- prescale is captured at start detection and held for the whole frame. A captured value of 0 is treated as 1.
- Bit counter is 4 bits wide. Prescale counter is 19 bits wide, unsigned; it never underflows.
- FSM states:
  - IDLE: when rxd_s==0, go to START, set busy=1, load counter = prescale*4-1 (half bit).
  - START: when counter reaches 0, sample rxd_s. If rxd_s==1 (glitch), return to IDLE with busy=0 and no output. Otherwise load counter = T-1, set bit_cnt = DATA_WIDTH, go to DATA.
  - DATA: at each counter expiry, shift rxd_s into the MSB of the shift register (LSB-first reception), decrement bit_cnt and reload T-1. When bit_cnt reaches 0, go to STOP.
  - STOP: at counter expiry, sample rxd_s.
    - If 1: the next cycle sets tdata = shift register and tvalid=1. If tvalid was already 1 and no handshake occurs in that cycle, also pulse overrun_error. Go to IDLE with busy=0.
    - If 0: pulse frame_error, discard the data (tvalid unchanged), go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd_s==1, then go to IDLE with busy=0. This prevents a break condition from re-triggering a start.
- Sample instants, measured from the cycle rxd_s first reads 0:
  - start bit at T/2;
  - data bit k at T/2 + (k+1)*T;
  - stop bit at T/2 + (DATA_WIDTH+1)*T.
- Handshake: a transfer occurs when tvalid && tready; tvalid drops the following cycle. tdata is stable while tvalid=1 and no new character completes.
- Simultaneous handshake and new character in the same cycle: tvalid stays 1, tdata takes the new value, no overrun.
- A new start bit is accepted in the cycle after returning to IDLE, so back-to-back frames with a single stop bit are received correctly.
- Asserting rst_n low mid-frame aborts the frame immediately: no output and no error pulse. After release the block is in IDLE and waits for the next falling edge.

Decomposition:
- Package uart_pkg holds:
  - the OVERSAMPLE=8 constant;
  - the rx state encoding (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the shared prescale width (16).
- The transmitter is updated to import OVERSAMPLE.
- One sub-module: uart_sync_2ff, a parameterised reset-value 2-flop synchronizer, reusable for other asynchronous inputs.

Test Plan:
- Send 0x55 on rxd, prescale=1 (T=8), tready=1 -> tvalid pulses one cycle with tdata=0x55; busy is high for about 76 cycles; no error pulses.
- Send 0xA3 then 0x3C back-to-back, tready held 0 -> after the second stop bit, overrun_error pulses once, tdata=0x3C, tvalid stays 1; raising tready consumes 0x3C.
- Send 0x00 with the stop bit forced low, followed by 20 cycles low -> frame_error pulses once, tvalid stays 0, busy stays 1 until rxd returns high; a following 0xFF frame is received correctly.
- 3-cycle low glitch on rxd, prescale=4 (T=32) -> no tvalid, no errors, busy high for 16 cycles then low.
- rst_n pulsed low halfway through receiving 0x81 -> all outputs return to reset values immediately; the next 0x81 frame is received correctly.
- prescale=0 with a 0x5A frame at T=8 -> received as 0x5A, identical to the prescale=1 case.
